// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe
//   EX/MEM and MEM/WB pipeline registers plus the MEM-stage data-memory
//   handshake. A memory op sitting in EX/MEM drives mem_req until mem_ready.
//   While it waits, pipe_hold freezes the upstream stages and EX/MEM holds
//   its contents. During the same wait, MEM/WB receives bubbles.
//
// Ports
//   clk, rst              : clock, async active-high reset
//   ex_*                  : instruction leaving EX (valid, ctrl, rd, data)
//   ex_flush, EX_stall    : either one turns the EX instruction into a bubble
//   mem_req/we/addr/wdata : data-memory request, combinational from EX/MEM
//   mem_ready, mem_rdata  : memory completion and load data
//   pipe_hold             : freeze PC/IF/ID/EX this cycle
//   EX_MEM_*, MEM_WB_*    : pipeline register contents for forwarding/hazards
//   hold_cycles           : saturating count of held cycles
module ex_mem_wb_pipe #(
    parameter int XLEN       = 32,
    parameter int HOLD_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_flush,
    input  logic                  EX_stall,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic                  ex_memwrite,
    input  logic                  ex_memtoreg,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ready,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  pipe_hold,
    output logic [4:0]            EX_MEM_rd,
    output logic                  EX_MEM_regwrite,
    output logic [XLEN-1:0]       EX_MEM_ALU_result,
    output logic                  EX_MEM_memtoreg,
    output logic                  EX_MEM_memread,
    output logic [4:0]            MEM_WB_rd,
    output logic [XLEN-1:0]       MEM_WB_result,
    output logic                  MEM_WB_regwrite,
    output logic [HOLD_CNT_W-1:0] hold_cycles
);

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    // EX/MEM
    logic            r_em_valid;
    logic [4:0]      r_em_rd;
    logic            r_em_regwrite;
    logic            r_em_memread;
    logic            r_em_memwrite;
    logic            r_em_memtoreg;
    logic [XLEN-1:0] r_em_alu;
    logic [XLEN-1:0] r_em_wdata;

    // MEM/WB
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_result;
    logic            r_wb_regwrite;

    logic [HOLD_CNT_W-1:0] r_hold_cycles;
    mem_state_t            r_state;
    mem_state_t            w_state_nxt;

    logic w_bubble;
    logic w_mem_op;
    logic w_pipe_hold;

    assign w_bubble    = !ex_valid | ex_flush | EX_stall;
    assign w_mem_op    = r_em_valid & (r_em_memread | r_em_memwrite);
    // A held access keeps EX/MEM frozen, so the request stays stable while waiting.
    assign w_pipe_hold = w_mem_op & !mem_ready;

    assign mem_req   = w_mem_op;
    assign mem_we    = r_em_memwrite;
    assign mem_addr  = r_em_alu;
    assign mem_wdata = r_em_wdata;
    assign pipe_hold = w_pipe_hold;

    assign EX_MEM_rd         = r_em_rd;
    assign EX_MEM_regwrite   = r_em_regwrite;
    assign EX_MEM_ALU_result = r_em_alu;
    assign EX_MEM_memtoreg   = r_em_memtoreg;
    assign EX_MEM_memread    = r_em_memread;
    assign MEM_WB_rd         = r_wb_rd;
    assign MEM_WB_result     = r_wb_result;
    assign MEM_WB_regwrite   = r_wb_regwrite;
    assign hold_cycles       = r_hold_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_em_valid    <= 1'b0;
            r_em_rd       <= '0;
            r_em_regwrite <= 1'b0;
            r_em_memread  <= 1'b0;
            r_em_memwrite <= 1'b0;
            r_em_memtoreg <= 1'b0;
            r_em_alu      <= '0;
            r_em_wdata    <= '0;
        end else if (!w_pipe_hold) begin
            if (w_bubble) begin
                r_em_valid    <= 1'b0;
                r_em_rd       <= '0;
                r_em_regwrite <= 1'b0;
                r_em_memread  <= 1'b0;
                r_em_memwrite <= 1'b0;
                r_em_memtoreg <= 1'b0;
                r_em_alu      <= '0;
                r_em_wdata    <= '0;
            end else begin
                r_em_valid    <= 1'b1;
                r_em_rd       <= ex_rd;
                // Writes to x0 are dropped here so forwarding never sees them.
                r_em_regwrite <= ex_regwrite & (ex_rd != 5'd0);
                r_em_memread  <= ex_memread;
                r_em_memwrite <= ex_memwrite;
                r_em_memtoreg <= ex_memtoreg;
                r_em_alu      <= ex_alu_result;
                r_em_wdata    <= ex_store_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_rd       <= '0;
            r_wb_result   <= '0;
            r_wb_regwrite <= 1'b0;
        end else if (w_pipe_hold) begin
            r_wb_rd       <= '0;
            r_wb_result   <= '0;
            r_wb_regwrite <= 1'b0;
        end else begin
            r_wb_rd       <= r_em_rd;
            r_wb_result   <= r_em_memtoreg ? mem_rdata : r_em_alu;
            r_wb_regwrite <= r_em_valid & r_em_regwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cycles <= '0;
        end else if (w_pipe_hold && (r_hold_cycles != '1)) begin
            r_hold_cycles <= r_hold_cycles + 1'b1;
        end
    end

    // The state is for observability only; pipe_hold alone steers the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MEM_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MEM_IDLE: if (w_mem_op && !mem_ready) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready)              w_state_nxt = MEM_IDLE;
            default:                              w_state_nxt = MEM_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
module tb_ex_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_flush = 1'b0, EX_stall = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_regwrite = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0, ex_memtoreg = 1'b0;
    logic [31:0] ex_alu_result = '0, ex_store_data = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata = '0;
    logic        pipe_hold;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite, EX_MEM_memtoreg, EX_MEM_memread;
    logic [31:0] EX_MEM_ALU_result;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_result;
    logic        MEM_WB_regwrite;
    logic [15:0] hold_cycles;

    int checks = 0;
    int failures = 0;

    ex_mem_wb_pipe #(.XLEN(32), .HOLD_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_flush(ex_flush), .EX_stall(EX_stall),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pipe_hold(pipe_hold),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_regwrite(EX_MEM_regwrite),
        .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_memtoreg(EX_MEM_memtoreg),
        .EX_MEM_memread(EX_MEM_memread), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_regwrite(MEM_WB_regwrite),
        .hold_cycles(hold_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one EX-stage instruction.
    task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                          input logic mw, input logic mtr, input logic [31:0] alu,
                          input logic [31:0] sd);
        ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr;
        ex_memwrite = mw; ex_memtoreg = mtr; ex_alu_result = alu; ex_store_data = sd;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_mem_req",   32'(mem_req), 32'h0);
        chk("rst_hold",      32'(pipe_hold), 32'h0);
        chk("rst_em_rd",     32'(EX_MEM_rd), 32'h0);
        chk("rst_wb_res",    MEM_WB_result, 32'h0);
        chk("rst_hold_cnt",  32'(hold_cycles), 32'h0);
        rst = 1'b0;

        // ALU back-to-back
        set_ex(1, 5'd5, 1, 0, 0, 0, 32'h10, 32'h0);
        tick();
        chk("alu1_em_rd", 32'(EX_MEM_rd), 32'd5);
        chk("alu1_em_rw", 32'(EX_MEM_regwrite), 32'h1);
        chk("alu1_hold",  32'(pipe_hold), 32'h0);
        set_ex(1, 5'd6, 1, 0, 0, 0, 32'h20, 32'h0);
        tick();
        chk("alu2_wb_rd",  32'(MEM_WB_rd), 32'd5);
        chk("alu2_wb_res", MEM_WB_result, 32'h10);
        chk("alu2_wb_rw",  32'(MEM_WB_regwrite), 32'h1);
        chk("alu2_em_rd",  32'(EX_MEM_rd), 32'd6);
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("alu3_wb_rd",  32'(MEM_WB_rd), 32'd6);
        chk("alu3_wb_res", MEM_WB_result, 32'h20);

        // Load with two wait cycles; EX_stall during the wait must be ignored
        mem_ready = 1'b0;
        set_ex(1, 5'd7, 1, 1, 0, 1, 32'h100, 32'h0);
        tick();
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("ld_req1",  32'(mem_req), 32'h1);
        chk("ld_we1",   32'(mem_we), 32'h0);
        chk("ld_addr1", mem_addr, 32'h100);
        chk("ld_hold1", 32'(pipe_hold), 32'h1);
        set_ex(1, 5'd3, 1, 0, 0, 0, 32'h33, 32'h0);
        EX_stall = 1'b1;
        tick();
        chk("ld_req2",   32'(mem_req), 32'h1);
        chk("ld_hold2",  32'(pipe_hold), 32'h1);
        chk("ld_wb_rw2", 32'(MEM_WB_regwrite), 32'h0);
        chk("ld_cnt2",   32'(hold_cycles), 32'd1);
        tick();
        chk("ld_em_rd3", 32'(EX_MEM_rd), 32'd7);
        chk("ld_em_mr3", 32'(EX_MEM_memread), 32'h1);
        chk("ld_wb_rw3", 32'(MEM_WB_regwrite), 32'h0);
        chk("ld_cnt3",   32'(hold_cycles), 32'd2);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        EX_stall = 1'b0;
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("ld_req3",  32'(mem_req), 32'h1);
        chk("ld_addr3", mem_addr, 32'h100);
        chk("ld_hold3", 32'(pipe_hold), 32'h0);
        tick();
        chk("ld_wb_rd",  32'(MEM_WB_rd), 32'd7);
        chk("ld_wb_res", MEM_WB_result, 32'hDEADBEEF);
        chk("ld_wb_rw",  32'(MEM_WB_regwrite), 32'h1);
        chk("ld_req_off", 32'(mem_req), 32'h0);
        chk("ld_cnt_end", 32'(hold_cycles), 32'd2);

        // Store, ready immediately
        set_ex(1, 5'd0, 0, 0, 1, 0, 32'h40, 32'h55);
        tick();
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("st_req",   32'(mem_req), 32'h1);
        chk("st_we",    32'(mem_we), 32'h1);
        chk("st_addr",  mem_addr, 32'h40);
        chk("st_wdata", mem_wdata, 32'h55);
        chk("st_hold",  32'(pipe_hold), 32'h0);
        tick();
        chk("st_wb_rw", 32'(MEM_WB_regwrite), 32'h0);
        chk("st_req_off", 32'(mem_req), 32'h0);
        chk("st_cnt",   32'(hold_cycles), 32'd2);

        // Bubbles: stall, flush, both
        set_ex(1, 5'd3, 1, 1, 0, 1, 32'h80, 32'h0);
        EX_stall = 1'b1;
        tick();
        chk("stall_em_rw", 32'(EX_MEM_regwrite), 32'h0);
        chk("stall_em_mr", 32'(EX_MEM_memread), 32'h0);
        chk("stall_req",   32'(mem_req), 32'h0);
        EX_stall = 1'b0; ex_flush = 1'b1;
        tick();
        chk("flush_em_rw", 32'(EX_MEM_regwrite), 32'h0);
        chk("flush_em_mr", 32'(EX_MEM_memread), 32'h0);
        EX_stall = 1'b1;
        tick();
        chk("both_em_rw", 32'(EX_MEM_regwrite), 32'h0);
        chk("both_req",   32'(mem_req), 32'h0);
        EX_stall = 1'b0; ex_flush = 1'b0;

        // x0 destination: ALU op, then a load that still accesses memory
        set_ex(1, 5'd0, 1, 0, 0, 0, 32'h77, 32'h0);
        tick();
        chk("x0_em_rw",  32'(EX_MEM_regwrite), 32'h0);
        chk("x0_em_alu", EX_MEM_ALU_result, 32'h77);
        set_ex(1, 5'd0, 1, 1, 0, 1, 32'h84, 32'h0);
        mem_rdata = 32'h1234;
        tick();
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("x0ld_req",  32'(mem_req), 32'h1);
        chk("x0ld_hold", 32'(pipe_hold), 32'h0);
        tick();
        chk("x0ld_wb_rw", 32'(MEM_WB_regwrite), 32'h0);

        // Async reset in the middle of a wait
        mem_ready = 1'b0;
        set_ex(1, 5'd9, 1, 1, 0, 1, 32'h200, 32'h0);
        tick();
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("ar_pre_hold", 32'(pipe_hold), 32'h1);
        chk("ar_pre_cnt",  32'(hold_cycles), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("ar_req",  32'(mem_req), 32'h0);
        chk("ar_hold", 32'(pipe_hold), 32'h0);
        chk("ar_cnt",  32'(hold_cycles), 32'h0);
        chk("ar_em_rd", 32'(EX_MEM_rd), 32'h0);
        chk("ar_em_mr", 32'(EX_MEM_memread), 32'h0);
        chk("ar_em_alu", EX_MEM_ALU_result, 32'h0);
        #1 rst = 1'b0;
        // After release, a fresh wait counts from zero
        set_ex(1, 5'd4, 1, 1, 0, 1, 32'h300, 32'h0);
        tick();
        set_ex(0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("post_hold", 32'(pipe_hold), 32'h1);
        chk("post_cnt0", 32'(hold_cycles), 32'h0);
        tick();
        chk("post_cnt1", 32'(hold_cycles), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
        tick();
        chk("post_wb_rd",  32'(MEM_WB_rd), 32'd4);
        chk("post_wb_res", MEM_WB_result, 32'hCAFE0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
